datacache_sram_arbiter: RTL and testbench



---
 rtl/datacache_sram_arbiter.sv | 177 +++++++++++++++++
 tb/tb_datacache_sram_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datacache_sram_arbiter.sv
// -----------------------------------------------------------------------------
// datacache_sram_arbiter
//   Shares the RW port (port 0) of the data-cache SRAM between two requesters:
//   m0 (core LSU) and m1 (refill/debug). Round-robin arbitration with an
//   optional per-master lock, single-cycle issue, and a fixed one-cycle read
//   response (rvalid is high in the cycle after the read is accepted, while
//   rdata passes sram_dout0 straight through).
//
//   Optional feature: define DCARB_INIT_CLEAR_EN to zero the whole SRAM after
//   every reset (INIT_CLR state, one word per cycle) before arbitration starts.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   mX_req/we/lock               request valid, 1=write, keep grant while held
//   mX_wmask/addr/wdata          byte enables (writes), word address, write data
//   mX_gnt                       combinational grant; accept = req & gnt
//   mX_rvalid/rdata              read response (rdata is 0 when rvalid is 0)
//   sram_csb0/web0/wmask0/       SRAM port-0 controls (active-low select and
//   sram_addr0/din0/dout0        write enable), address, write/read data
//   init_done                    arbiter is accepting requests
// -----------------------------------------------------------------------------
module datacache_sram_arbiter #(
   parameter int ADDR_WIDTH = 11,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_WMASKS = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  m0_req,
   input  logic                  m0_we,
   input  logic                  m0_lock,
   input  logic [NUM_WMASKS-1:0] m0_wmask,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_gnt,
   output logic                  m0_rvalid,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_we,
   input  logic                  m1_lock,
   input  logic [NUM_WMASKS-1:0] m1_wmask,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_gnt,
   output logic                  m1_rvalid,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [NUM_WMASKS-1:0] sram_wmask0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0,
   output logic                  init_done
);

   typedef enum logic [1:0] {OWN_NONE, OWN_M0, OWN_M1} owner_e;

`ifdef DCARB_INIT_CLEAR_EN
   typedef enum logic {ST_INIT_CLR, ST_RUN} state_e;
   localparam state_e RESET_STATE = ST_INIT_CLR;
`else
   typedef enum logic {ST_RUN} state_e;
   localparam state_e RESET_STATE = ST_RUN;
`endif

   state_e r_state, w_state_nxt;
   owner_e r_owner, w_owner_nxt;
   logic   r_last_m1, w_last_m1_nxt;   // 1 = m1 was granted last
   logic   r_rvalid0, r_rvalid1;
   logic   w_own0, w_own1;

`ifdef DCARB_INIT_CLEAR_EN
   logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_addr_nxt;
`endif

   assign w_own0 = (r_owner == OWN_M0);
   assign w_own1 = (r_owner == OWN_M1);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of the others, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= RESET_STATE;
         r_owner    <= OWN_NONE;
         r_last_m1  <= 1'b1;            // m0 wins the first contention
         r_rvalid0  <= 1'b0;
         r_rvalid1  <= 1'b0;
`ifdef DCARB_INIT_CLEAR_EN
         r_clr_addr <= '0;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_owner    <= w_owner_nxt;
         r_last_m1  <= w_last_m1_nxt;
         r_rvalid0  <= m0_gnt & ~m0_we;
         r_rvalid1  <= m1_gnt & ~m1_we;
`ifdef DCARB_INIT_CLEAR_EN
         r_clr_addr <= w_clr_addr_nxt;
`endif
      end
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt   = r_state;
      w_owner_nxt   = r_owner;
      w_last_m1_nxt = r_last_m1;
      m0_gnt        = 1'b0;
      m1_gnt        = 1'b0;
      sram_csb0     = 1'b1;
      sram_web0     = 1'b1;
      sram_wmask0   = '0;
      sram_addr0    = '0;
      sram_din0     = '0;
`ifdef DCARB_INIT_CLEAR_EN
      w_clr_addr_nxt = r_clr_addr;
`endif
      // Reset gates the grants and the SRAM strobes, so nothing is issued
      // while rst_n is low even with requests pending.
      if (rst_n) begin
         case (r_state)
`ifdef DCARB_INIT_CLEAR_EN
            ST_INIT_CLR: begin
               sram_csb0      = 1'b0;
               sram_web0      = 1'b0;
               sram_wmask0    = '1;
               sram_addr0     = r_clr_addr;
               w_clr_addr_nxt = r_clr_addr + 1'b1;   // wraps back to 0
               if (&r_clr_addr) w_state_nxt = ST_RUN;
            end
`endif
            ST_RUN: begin
               // A live lock owner wins; otherwise the master not granted last.
               m0_gnt = m0_req & (~m1_req | w_own0 | (~w_own1 & r_last_m1));
               m1_gnt = m1_req & (~m0_req | w_own1 | (~w_own0 & ~r_last_m1));

               // Owner dropping its request releases the lock.
               if ((w_own0 & ~m0_req) | (w_own1 & ~m1_req)) w_owner_nxt = OWN_NONE;

               if (m0_gnt) begin
                  w_owner_nxt   = m0_lock ? OWN_M0 : OWN_NONE;
                  w_last_m1_nxt = 1'b0;
                  sram_csb0     = 1'b0;
                  sram_web0     = ~m0_we;
                  sram_wmask0   = m0_we ? m0_wmask : '0;
                  sram_addr0    = m0_addr;
                  sram_din0     = m0_wdata;
               end else if (m1_gnt) begin
                  w_owner_nxt   = m1_lock ? OWN_M1 : OWN_NONE;
                  w_last_m1_nxt = 1'b1;
                  sram_csb0     = 1'b0;
                  sram_web0     = ~m1_we;
                  sram_wmask0   = m1_we ? m1_wmask : '0;
                  sram_addr0    = m1_addr;
                  sram_din0     = m1_wdata;
               end
            end
            default: ;
         endcase
      end
   end

   // SRAM data settles after the negedge following capture, i.e. within the
   // cycle where the registered rvalid is high.
   assign m0_rvalid = r_rvalid0;
   assign m1_rvalid = r_rvalid1;
   assign m0_rdata  = r_rvalid0 ? sram_dout0 : '0;
   assign m1_rdata  = r_rvalid1 ? sram_dout0 : '0;

`ifdef DCARB_INIT_CLEAR_EN
   assign init_done = (r_state == ST_RUN);
`else
   assign init_done = 1'b1;
`endif

endmodule

// File: tb/tb_datacache_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_datacache_sram_arbiter
//   Self-checking bench for datacache_sram_arbiter with a behavioural SRAM on
//   port 0. Read expectations are pushed to a scoreboard queue when a read is
//   expected to be accepted and popped in the following cycle when rvalid is
//   due. Grants come from a small round-robin/lock model of the arbiter.
//   Honours DCARB_INIT_CLEAR_EN for the init-clear sequence.
// -----------------------------------------------------------------------------
module tb_datacache_sram_arbiter;

   localparam int AW    = 11;
   localparam int DW    = 32;
   localparam int NW    = 4;
   localparam int DEPTH = 2048;

   typedef struct packed {
      logic          req;
      logic          we;
      logic          lock;
      logic [NW-1:0] wmask;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   typedef struct {
      logic          m;      // 0 = m0, 1 = m1
      logic [DW-1:0] data;
   } rsp_t;

   localparam req_t IDLE = '0;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
   logic [NW-1:0] m0_wmask;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
   logic [NW-1:0] m1_wmask;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic          sram_csb0, sram_web0, init_done;
   logic [NW-1:0] sram_wmask0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0, sram_dout0;

   datacache_sram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_wmask(m0_wmask),
      .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_wmask(m1_wmask),
      .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
      .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
      .init_done(init_done)
   );

   // Behavioural SRAM port 0 plus a backdoor used for preloading.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_q;
   logic          bd_we;
   logic [AW-1:0] bd_addr;
   logic [DW-1:0] bd_data;

   always @(posedge clk) begin
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (!sram_csb0) begin
         if (!sram_web0) begin
            for (int b = 0; b < NW; b++)
               if (sram_wmask0[b]) mem[sram_addr0][b*8 +: 8] <= sram_din0[b*8 +: 8];
         end else begin
            rd_q <= mem[sram_addr0];
         end
      end
   end

   always @(negedge clk) sram_dout0 <= rd_q;

   // Reference contents, arbiter model and scoreboard.
   logic [DW-1:0] ref_mem [DEPTH];
   logic          exp_last_m1;
   int            exp_owner;        // 0 none, 1 m0, 2 m1
   rsp_t          sb [$];
   int            n_checks = 0;
   int            n_errors = 0;
   int            m1_gnt_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic req_t rd(input logic [AW-1:0] addr, input logic lock);
      req_t r = IDLE;
      r.req  = 1'b1;
      r.lock = lock;
      r.addr = addr;
      return r;
   endfunction

   function automatic req_t wr(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic [NW-1:0] mask);
      req_t r = IDLE;
      r.req   = 1'b1;
      r.we    = 1'b1;
      r.wmask = mask;
      r.addr  = addr;
      r.wdata = data;
      return r;
   endfunction

   task automatic apply(input req_t a, input req_t b);
      m0_req = a.req; m0_we = a.we; m0_lock = a.lock; m0_wmask = a.wmask;
      m0_addr = a.addr; m0_wdata = a.wdata;
      m1_req = b.req; m1_we = b.we; m1_lock = b.lock; m1_wmask = b.wmask;
      m1_addr = b.addr; m1_wdata = b.wdata;
   endtask

   task automatic model_reset();
      exp_last_m1 = 1'b1;
      exp_owner   = 0;
      sb.delete();
   endtask

   // One bus cycle: called just after a posedge, returns just after the next.
   task automatic drive_cycle(input req_t a, input req_t b);
      logic g0, g1;
      req_t w;
      rsp_t e;
      apply(a, b);
      g0 = 1'b0;
      g1 = 1'b0;
      if (a.req && b.req) begin
         if (exp_owner == 1)      g0 = 1'b1;
         else if (exp_owner == 2) g1 = 1'b1;
         else if (exp_last_m1)    g0 = 1'b1;
         else                     g1 = 1'b1;
      end else begin
         g0 = a.req;
         g1 = b.req;
      end

      @(negedge clk); #1;
      // Response due from the previous cycle's read, if any.
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (!e.m) begin
            check("m0_rvalid", m0_rvalid, 1);
            check("m0_rdata", m0_rdata, e.data);
            check("m1_rvalid_quiet", m1_rvalid, 0);
         end else begin
            check("m1_rvalid", m1_rvalid, 1);
            check("m1_rdata", m1_rdata, e.data);
            check("m0_rvalid_quiet", m0_rvalid, 0);
         end
      end else begin
         check("rvalid_idle", {m0_rvalid, m1_rvalid}, 0);
         check("rdata_idle", m0_rdata | m1_rdata, 0);
      end

      check("m0_gnt", m0_gnt, g0);
      check("m1_gnt", m1_gnt, g1);
      check("gnt_onehot", m0_gnt & m1_gnt, 0);
      m1_gnt_seen += m1_gnt;

      if (g0 || g1) begin
         w = g0 ? a : b;
         check("csb0", sram_csb0, 0);
         check("web0", sram_web0, !w.we);
         check("addr0", sram_addr0, w.addr);
         check("wmask0", sram_wmask0, w.we ? w.wmask : 4'h0);
         if (w.we) begin
            check("din0", sram_din0, w.wdata);
            for (int i = 0; i < NW; i++)
               if (w.wmask[i]) ref_mem[w.addr][i*8 +: 8] = w.wdata[i*8 +: 8];
         end else begin
            sb.push_back('{g1, ref_mem[w.addr]});
         end
         exp_last_m1 = g1;
         exp_owner   = w.lock ? (g1 ? 2 : 1) : 0;
      end else begin
         check("csb0_idle", sram_csb0, 1);
         if ((exp_owner == 1 && !a.req) || (exp_owner == 2 && !b.req)) exp_owner = 0;
      end

      @(posedge clk); #1;
   endtask

   // Release reset at a negedge and wait until the arbiter is ready.
   task automatic release_reset();
`ifdef DCARB_INIT_CLEAR_EN
      int   n;
      logic gseen;
      apply(rd(11'h001, 1'b0), rd(11'h002, 1'b0));   // must stay ungranted
      @(negedge clk);
      rst_n = 1'b1;
      n     = 0;
      gseen = 1'b0;
      while (!init_done && n < 3000) begin
         gseen = gseen | m0_gnt | m1_gnt;
         @(posedge clk); #1;
         n++;
      end
      apply(IDLE, IDLE);
      check("init_cycles", n, 2048);
      check("init_gnt", gseen, 0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
`else
      apply(IDLE, IDLE);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      bd_we = 1'b0;
      bd_addr = '0;
      bd_data = '0;
      m1_gnt_seen = 0;
      model_reset();
      apply(rd(11'h005, 1'b0), rd(11'h006, 1'b0));   // requests held in reset
      @(posedge clk); #1;

      // Reset values with requests pending.
      check("rst_m0_gnt", m0_gnt, 0);
      check("rst_m1_gnt", m1_gnt, 0);
      check("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
      check("rst_rdata", m0_rdata | m1_rdata, 0);
      check("rst_csb0", sram_csb0, 1);
      check("rst_web0", sram_web0, 1);
      check("rst_wmask0", sram_wmask0, 0);
      check("rst_addr0", sram_addr0, 0);
      check("rst_din0", sram_din0, 0);
`ifdef DCARB_INIT_CLEAR_EN
      check("rst_init_done", init_done, 0);
`else
      check("rst_init_done", init_done, 1);
`endif

      // Preload nonzero data through the backdoor while held in reset.
      for (int i = 0; i < DEPTH; i++) begin
         bd_we   = 1'b1;
         bd_addr = AW'(i);
         bd_data = 32'hC0DE_0000 ^ i;
         ref_mem[i] = 32'hC0DE_0000 ^ i;
         @(posedge clk); #1;
      end
      bd_we = 1'b0;
      release_reset();

      // Write then read back on m0.
      drive_cycle(wr(11'h010, 32'hDEADBEEF, 4'hF), IDLE);
      drive_cycle(rd(11'h010, 1'b0), IDLE);
      drive_cycle(IDLE, IDLE);

      // Both masters read every cycle, no lock: grants alternate.
      for (int i = 0; i < 6; i++)
         drive_cycle(rd(AW'(11'h100 + i), 1'b0), rd(AW'(11'h200 + i), 1'b0));

      // m1 holds lock for 4 reads against a persistent m0 request.
      m1_gnt_seen = 0;
      for (int i = 0; i < 4; i++)
         drive_cycle(rd(11'h300, 1'b0), rd(AW'(11'h400 + i), 1'b1));
      check("lock_m1_grants", m1_gnt_seen, 4);
      drive_cycle(rd(11'h300, 1'b0), IDLE);

      // Partial-mask merge, then read-before-write ordering on one address.
      drive_cycle(wr(11'h020, 32'h11223344, 4'hF), IDLE);
      drive_cycle(wr(11'h020, 32'hAABBCCDD, 4'b0101), IDLE);
      drive_cycle(rd(11'h020, 1'b0), IDLE);
      drive_cycle(IDLE, wr(11'h020, 32'h00000055, 4'hF));
      drive_cycle(IDLE, rd(11'h020, 1'b0));
      drive_cycle(IDLE, rd(11'h7FF, 1'b0));
      drive_cycle(IDLE, IDLE);

      // Reset between a read grant and its response drops the response.
      drive_cycle(rd(11'h030, 1'b0), IDLE);
      rst_n = 1'b0;
      apply(IDLE, IDLE);
      #1;
      check("rst_drop_m0_rvalid", m0_rvalid, 0);
      check("rst_drop_m0_rdata", m0_rdata, 0);
      model_reset();
      @(posedge clk); #1;
      release_reset();
      drive_cycle(rd(11'h031, 1'b0), rd(11'h032, 1'b0));   // m0 must win
      drive_cycle(rd(11'h7FF, 1'b0), IDLE);
      drive_cycle(IDLE, IDLE);
      drive_cycle(IDLE, IDLE);
      check("sb_drained", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
